// File: rtl/mux_reg_nx1.sv
// mux_reg_nx1: registered NUM_IN:1 operand selector staged in a 2-entry skid buffer
// with valid/ready on both sides and a sticky illegal-select flag.
module mux_reg_nx1 #(
    parameter int WIDTH = 32,
    parameter int NUM_IN = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    flush,
    output logic                    sel_err,
    input  logic                    err_clr
);
    localparam logic [1:0] S_EMPTY = 2'd0, S_ONE = 2'd1, S_FULL = 2'd2;
    localparam logic [SEL_W:0] NUM_IN_W = NUM_IN[SEL_W:0];

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d, skid_q, skid_d, word;
    logic [SEL_W-1:0] src_q, src_d, skid_src_q, skid_src_d;
    logic             err_q, err_d, in_ready_q, out_valid_q;
    logic             sel_ok, accept, pop;

    always_comb begin
        sel_ok     = {1'b0, sel} < NUM_IN_W;
        word       = sel_ok ? in_data[sel*WIDTH +: WIDTH] : RESET_VAL;
        accept     = in_valid & in_ready_q;
        pop        = out_valid_q & out_ready;
        state_d    = state_q;
        head_d     = head_q;
        src_d      = src_q;
        skid_d     = skid_q;
        skid_src_d = skid_src_q;
        err_d      = (accept & ~sel_ok) | (err_q & ~err_clr);
        if (flush) begin
            state_d    = S_EMPTY;
            head_d     = RESET_VAL;
            src_d      = '0;
            skid_d     = RESET_VAL;
            skid_src_d = '0;
        end else if (state_q == S_EMPTY) begin
            if (accept) begin
                state_d = S_ONE;
                head_d  = word;
                src_d   = sel;
            end
        end else if (state_q == S_ONE) begin
            if (accept & ~pop) begin
                state_d    = S_FULL;
                skid_d     = word;
                skid_src_d = sel;
            end else if (pop & ~accept) begin
                state_d = S_EMPTY;
            end else if (accept) begin
                head_d = word;
                src_d  = sel;
            end
        end else if (pop) begin
            state_d = S_ONE;
            head_d  = skid_q;
            src_d   = skid_src_q;
        end
    end

    // Handshake outputs are flopped from the next state so out_ready never reaches in_ready combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            head_q      <= RESET_VAL;
            src_q       <= '0;
            skid_q      <= RESET_VAL;
            skid_src_q  <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            src_q       <= src_d;
            skid_q      <= skid_d;
            skid_src_q  <= skid_src_d;
            err_q       <= err_d;
            in_ready_q  <= state_d != S_FULL;
            out_valid_q <= state_d != S_EMPTY;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = head_q;
    assign out_src   = src_q;
    assign sel_err   = err_q;
endmodule

// File: tb/tb_mux_reg_nx1.sv
// tb_mux_reg_nx1: three instances (NUM_IN 3/2/8) driven by directed and random traffic;
// a negedge monitor compares each against a depth-2 FIFO queue model.
module tb_mux_reg_nx1;
    localparam logic [31:0] RV0 = 32'h5A5A0F0F;
    localparam logic [31:0] RV8 = 32'h000000A5;

    logic        clk = 1'b0, rst_n = 1'b0, rand_on = 1'b1;
    logic [2:0]  iv = '0, ordy = '0, fl = '0, ec = '0;
    logic [2:0]  ir, ov, se;
    logic [2:0]  sl [3];
    logic [95:0] din0 = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    logic [15:0] din1 = '0;
    logic [63:0] din2 = '0;
    logic [31:0] od0;
    logic [7:0]  od1, od2;
    logic [1:0]  os0;
    logic        os1;
    logic [2:0]  os2;
    int          n_cmp = 0, n_mis = 0;

    logic [34:0] sbq [3][$];
    bit          err_m [3];
    bit          rvf [3];
    logic [31:0] m_d;
    logic [2:0]  m_s;
    bit          m_acc, m_pop;

    always #5 clk = ~clk;

    mux_reg_nx1 #(.WIDTH(32), .NUM_IN(3), .RESET_VAL(RV0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_data(din0), .sel(sl[0][1:0]), .in_valid(iv[0]),
        .in_ready(ir[0]), .out_data(od0), .out_src(os0), .out_valid(ov[0]),
        .out_ready(ordy[0]), .flush(fl[0]), .sel_err(se[0]), .err_clr(ec[0]));
    mux_reg_nx1 #(.WIDTH(8), .NUM_IN(2), .RESET_VAL(8'hA5)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(din1), .sel(sl[1][0:0]), .in_valid(iv[1]),
        .in_ready(ir[1]), .out_data(od1), .out_src(os1), .out_valid(ov[1]),
        .out_ready(ordy[1]), .flush(fl[1]), .sel_err(se[1]), .err_clr(ec[1]));
    mux_reg_nx1 #(.WIDTH(8), .NUM_IN(8), .RESET_VAL(8'hA5)) u2 (
        .clk(clk), .rst_n(rst_n), .in_data(din2), .sel(sl[2]), .in_valid(iv[2]),
        .in_ready(ir[2]), .out_data(od2), .out_src(os2), .out_valid(ov[2]),
        .out_ready(ordy[2]), .flush(fl[2]), .sel_err(se[2]), .err_clr(ec[2]));

    function automatic int nin(int i);
        return i == 0 ? 3 : i == 1 ? 2 : 8;
    endfunction

    function automatic logic [31:0] rv(int i);
        return i == 0 ? RV0 : RV8;
    endfunction

    // The word a transfer should deliver: the selected slice, or the reset value if out of range
    function automatic logic [31:0] exp_word(int i, int s);
        if (s >= nin(i)) return rv(i);
        return i == 0 ? din0[s*32 +: 32] : i == 1 ? 32'(din1[s*8 +: 8]) : 32'(din2[s*8 +: 8]);
    endfunction

    task automatic chk(int i, string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL dut%0d %s: got %h expected %h at %0t", i, nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                sbq[i].delete();
                err_m[i] = 1'b0;
                rvf[i]   = 1'b1;
            end
            m_d = i == 0 ? od0 : i == 1 ? 32'(od1) : 32'(od2);
            m_s = i == 0 ? 3'(os0) : i == 1 ? 3'(os1) : os2;
            chk(i, "out_valid", 32'(ov[i]), 32'(sbq[i].size() > 0));
            chk(i, "in_ready", 32'(ir[i]), 32'(sbq[i].size() < 2));
            chk(i, "sel_err", 32'(se[i]), 32'(err_m[i]));
            if (sbq[i].size() > 0) begin
                chk(i, "out_data", m_d, sbq[i][0][31:0]);
                chk(i, "out_src", 32'(m_s), 32'(sbq[i][0][34:32]));
            end else if (rvf[i]) begin
                chk(i, "idle_data", m_d, rv(i));
                chk(i, "idle_src", 32'(m_s), 32'd0);
            end
            if (rst_n) begin
                m_acc = iv[i] && sbq[i].size() < 2;
                m_pop = ordy[i] && sbq[i].size() > 0;
                if (m_acc && int'(sl[i]) >= nin(i)) err_m[i] = 1'b1;
                else if (ec[i]) err_m[i] = 1'b0;
                if (fl[i]) begin
                    sbq[i].delete();
                    rvf[i] = 1'b1;
                end else begin
                    if (m_pop) void'(sbq[i].pop_front());
                    if (m_acc) begin
                        sbq[i].push_back({sl[i], exp_word(i, int'(sl[i]))});
                        rvf[i] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_on) begin
            for (int j = 1; j < 3; j++) begin
                iv[j]   = $urandom_range(0, 3) != 0;
                ordy[j] = $urandom_range(0, 2) != 0;
                fl[j]   = $urandom_range(0, 31) == 0;
                ec[j]   = $urandom_range(0, 15) == 0;
            end
            sl[1] = 3'($urandom_range(0, 1));
            sl[2] = 3'($urandom_range(0, 7));
            din1  = 16'($urandom);
            din2  = {$urandom, $urandom};
        end
    endtask

    task automatic send(int s);
        bit ok = 1'b0;
        iv[0] = 1'b1;
        sl[0] = 3'(s);
        for (int k = 0; k < 20 && !ok; k++) begin
            ok = ir[0];
            if (!ok) tick();
        end
        if (!ok) chk(0, "in_ready_wait", 32'(ir[0]), 32'd1);
        tick();
        iv[0] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) sl[i] = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        ordy[0] = 1'b1;
        for (int s = 0; s < 3; s++) send(s);
        repeat (3) tick();
        ordy[0] = 1'b0;
        send(0);
        send(1);
        iv[0] = 1'b1;
        sl[0] = 3'd2;
        repeat (3) tick();
        chk(0, "bp_in_ready", 32'(ir[0]), 32'd0);
        ordy[0] = 1'b1;
        send(2);
        repeat (3) tick();
        send(3);
        repeat (2) tick();
        chk(0, "err_held", 32'(se[0]), 32'd1);
        ec[0] = 1'b1;
        tick();
        ec[0] = 1'b0;
        tick();
        chk(0, "err_cleared", 32'(se[0]), 32'd0);
        ec[0] = 1'b1;
        send(3);
        ec[0] = 1'b0;
        tick();
        chk(0, "err_set_wins", 32'(se[0]), 32'd1);
        ec[0] = 1'b1;
        tick();
        ec[0] = 1'b0;
        ordy[0] = 1'b0;
        send(0);
        send(1);
        iv[0] = 1'b1;
        sl[0] = 3'd2;
        fl[0] = 1'b1;
        tick();
        fl[0] = 1'b0;
        iv[0] = 1'b0;
        tick();
        send(0);
        iv[0] = 1'b1;
        sl[0] = 3'd1;
        fl[0] = 1'b1;
        tick();
        fl[0] = 1'b0;
        iv[0] = 1'b0;
        tick();
        send(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk(0, "async_out_valid", 32'(ov[0]), 32'd0);
        chk(0, "async_in_ready", 32'(ir[0]), 32'd1);
        tick();
        rst_n = 1'b1;
        ordy[0] = 1'b1;
        for (int s = 0; s < 3; s++) send(s);
        repeat (3) tick();
        for (int c = 0; c < 2000; c++) begin
            iv[0]   = $urandom_range(0, 1) != 0;
            sl[0]   = 3'($urandom_range(0, 3));
            ordy[0] = $urandom_range(0, 2) != 0;
            fl[0]   = $urandom_range(0, 31) == 0;
            ec[0]   = $urandom_range(0, 15) == 0;
            din0    = {$urandom, $urandom, $urandom};
            tick();
        end
        rand_on = 1'b0;
        iv = '0;
        fl = '0;
        ec = '0;
        ordy = '1;
        repeat (4) tick();
        chk(1, "sweep_no_err", 32'(se[1]), 32'd0);
        chk(2, "sweep_no_err", 32'(se[2]), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
